// File: rtl/addr_dec_req_pkg.sv
// addr_dec_req_pkg: shared request type, widths and op-ID constants for the
// address-decoder request issuer.
package addr_dec_req_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned NUM_IDS = 1 << ID_W;

    localparam logic [ID_W-1:0] OP_ID_NONE  = 8'h00;
    localparam logic [ID_W-1:0] OP_ID_FIRST = 8'h01;
    localparam logic [ID_W-1:0] OP_ID_LAST  = 8'hFF;

    // One buffered host request
    typedef struct packed {
        logic              wr_rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    // ID sequence skips OP_ID_NONE: ... 254, 255, 1, 2 ...
    function automatic logic [ID_W-1:0] next_op_id(input logic [ID_W-1:0] id);
        return (id == OP_ID_LAST) ? OP_ID_FIRST : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/addr_dec_req_fifo.sv
// addr_dec_req_fifo: synchronous FIFO of req_t with pointer-derived
// full/empty flags. Pushes while full and pops while empty are ignored.
module addr_dec_req_fifo
    import addr_dec_req_pkg::*;
#(
    parameter int unsigned DEPTH = 8
)
(
    input  logic clock,
    input  logic rst_n,
    input  logic push,
    input  req_t push_req,
    input  logic pop,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    req_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_req;
    end

endmodule

// File: rtl/addr_dec_req_issuer.sv
// addr_dec_req_issuer: buffers host requests, tags each with a non-zero op ID,
// issues them to the address decoder and turns decoder completions into
// one-cycle host completion pulses.
// Optional build macro ADDR_DEC_REQ_TIMEOUT_EN adds a 16-bit age counter and
// a sticky timeout_err output.
module addr_dec_req_issuer
    import addr_dec_req_pkg::*;
#(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned MAX_OUTSTANDING = 16
)
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic              push_wr_rd,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    output logic              enable_in,
    output logic              valid_in,
    output logic              wr_rd_op,
    output logic [ADDR_W-1:0] addr_in,
    output logic [ID_W-1:0]   op_id_in,
    output logic [DATA_W-1:0] wr_data_in,
    input  logic              ready_out,
    input  logic [ID_W-1:0]   done_op_id,
    input  logic [DATA_W-1:0] rd_data_out,
    output logic              cpl_valid,
    output logic [ID_W-1:0]   cpl_op_id,
    output logic              cpl_wr_rd,
    output logic [DATA_W-1:0] cpl_rd_data,
    output logic              cpl_err,
    output logic [ID_W-1:0]   outstanding
`ifdef ADDR_DEC_REQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    logic               ready_q;
    logic [ID_W-1:0]    next_id;
    logic [NUM_IDS-1:0] busy;
    logic [NUM_IDS-1:0] is_wr;

    req_t               push_req;
    req_t               head;
    logic               fifo_full;
    logic               fifo_empty;

    logic               stall;
    logic               issue;
    logic               done_nz;
    logic               cpl_hit;
    logic               cpl_miss;

    assign push_req = '{wr_rd: push_wr_rd, addr: push_addr, data: push_data};

    addr_dec_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .rst_n    (rst_n),
        .push     (push_valid && push_ready),
        .push_req (push_req),
        .pop      (issue),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Held low through reset so the host sees no space until the block is live
    always_ff @(posedge clock) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign push_ready = ready_q && !fifo_full;
    assign enable_in  = ready_q;

    // Issue is a pure function of registered state; stall can only rise on an issue
    assign stall    = (outstanding == ID_W'(MAX_OUTSTANDING)) || busy[next_id];
    assign valid_in = !fifo_empty && !stall;
    assign issue    = valid_in && ready_out;

    // Request bus is zeroed when idle so stale FIFO contents never leak out
    assign wr_rd_op   = valid_in ? head.wr_rd : 1'b0;
    assign addr_in    = valid_in ? head.addr  : '0;
    assign wr_data_in = valid_in ? head.data  : '0;
    assign op_id_in   = valid_in ? next_id    : OP_ID_NONE;

    // A completion for an ID not currently in flight (including the one being
    // issued this very cycle) is an error rather than a completion
    assign done_nz  = (done_op_id != OP_ID_NONE);
    assign cpl_hit  = done_nz && busy[done_op_id];
    assign cpl_miss = done_nz && !busy[done_op_id];

    // Scoreboard: in-flight bitmap, ID allocator and outstanding count
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            next_id     <= OP_ID_FIRST;
            busy        <= '0;
            outstanding <= '0;
        end else begin
            if (issue) begin
                busy[next_id] <= 1'b1;
                next_id       <= next_op_id(next_id);
            end
            if (cpl_hit) begin
                busy[done_op_id] <= 1'b0;
            end
            case ({issue, cpl_hit})
                2'b10:   outstanding <= outstanding + ID_W'(1);
                2'b01:   outstanding <= outstanding - ID_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Request type per in-flight ID; only read while the busy bit is set
    always_ff @(posedge clock) begin
        if (issue) is_wr[next_id] <= head.wr_rd;
    end

    // Completion pulse and sticky unknown-ID error
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cpl_valid   <= 1'b0;
            cpl_op_id   <= OP_ID_NONE;
            cpl_wr_rd   <= 1'b0;
            cpl_rd_data <= '0;
            cpl_err     <= 1'b0;
        end else begin
            cpl_valid   <= cpl_hit;
            cpl_op_id   <= cpl_hit ? done_op_id : OP_ID_NONE;
            cpl_wr_rd   <= cpl_hit && is_wr[done_op_id];
            cpl_rd_data <= (cpl_hit && !is_wr[done_op_id]) ? rd_data_out : '0;
            cpl_err     <= cpl_err || cpl_miss;
        end
    end

`ifdef ADDR_DEC_REQ_TIMEOUT_EN
    logic [15:0] age_q;

    // Cycles since the last completion while work is in flight; saturates
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            age_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (cpl_hit) begin
                age_q <= '0;
            end else if ((outstanding != '0) && (age_q != 16'hFFFF)) begin
                age_q <= age_q + 16'd1;
            end
            if (age_q == 16'hFFFF) timeout_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_addr_dec_req_issuer.sv
// tb_addr_dec_req_issuer: table-driven directed vectors, hand-written corner
// sequences and randomized traffic, all compared every cycle against a
// queue-based reference model of the issuer.
module tb_addr_dec_req_issuer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned MAXO  = 2;

    logic       clock;
    logic       rst_n;
    logic       push_valid;
    logic       push_ready;
    logic       push_wr_rd;
    logic [7:0] push_addr;
    logic [7:0] push_data;
    logic       enable_in;
    logic       valid_in;
    logic       wr_rd_op;
    logic [7:0] addr_in;
    logic [7:0] op_id_in;
    logic [7:0] wr_data_in;
    logic       ready_out;
    logic [7:0] done_op_id;
    logic [7:0] rd_data_out;
    logic       cpl_valid;
    logic [7:0] cpl_op_id;
    logic       cpl_wr_rd;
    logic [7:0] cpl_rd_data;
    logic       cpl_err;
    logic [7:0] outstanding;

    int checks = 0;
    int errors = 0;

    addr_dec_req_issuer #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_wr_rd  (push_wr_rd),
        .push_addr   (push_addr),
        .push_data   (push_data),
        .enable_in   (enable_in),
        .valid_in    (valid_in),
        .wr_rd_op    (wr_rd_op),
        .addr_in     (addr_in),
        .op_id_in    (op_id_in),
        .wr_data_in  (wr_data_in),
        .ready_out   (ready_out),
        .done_op_id  (done_op_id),
        .rd_data_out (rd_data_out),
        .cpl_valid   (cpl_valid),
        .cpl_op_id   (cpl_op_id),
        .cpl_wr_rd   (cpl_wr_rd),
        .cpl_rd_data (cpl_rd_data),
        .cpl_err     (cpl_err),
        .outstanding (outstanding)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] data;
    } mreq_t;

    mreq_t    m_q[$];
    int       m_issued[$];
    bit       m_type[256];
    int       m_nid;
    bit       m_rdy;
    bit       m_cpl_v;
    int       m_cpl_id;
    bit       m_cpl_wr;
    bit [7:0] m_cpl_rd;
    bit       m_err;

    function automatic bit is_out(input int id);
        foreach (m_issued[i]) if (m_issued[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_push_ready();
        return m_rdy && (m_q.size() < int'(DEPTH));
    endfunction

    function automatic bit m_valid();
        return (m_q.size() > 0) && (m_issued.size() < int'(MAXO)) && !is_out(m_nid);
    endfunction

    // Advance the model across one rising edge using the current inputs
    task automatic model_next();
        bit v, iss, pr, hit, miss;
        int d;
        if (!rst_n) begin
            m_q.delete();
            m_issued.delete();
            m_nid = 1; m_rdy = 0;
            m_cpl_v = 0; m_cpl_id = 0; m_cpl_wr = 0; m_cpl_rd = 0; m_err = 0;
            return;
        end
        v    = m_valid();
        iss  = v && ready_out;
        pr   = m_push_ready();
        d    = int'(done_op_id);
        hit  = (d != 0) && is_out(d);
        miss = (d != 0) && !hit;
        m_cpl_v  = hit;
        m_cpl_id = hit ? d : 0;
        m_cpl_wr = hit ? m_type[d] : 1'b0;
        m_cpl_rd = (hit && !m_type[d]) ? rd_data_out : 8'h00;
        if (miss) m_err = 1;
        if (hit) begin
            for (int i = 0; i < m_issued.size(); i++) begin
                if (m_issued[i] == d) begin
                    m_issued.delete(i);
                    break;
                end
            end
        end
        if (iss) begin
            m_type[m_nid] = m_q[0].wr;
            m_issued.push_back(m_nid);
            void'(m_q.pop_front());
            m_nid = (m_nid == 255) ? 1 : m_nid + 1;
        end
        if (push_valid && pr) m_q.push_back('{wr: push_wr_rd, addr: push_addr, data: push_data});
        m_rdy = 1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        bit v;
        v = m_valid();
        chk("mdl_push_ready",  8'(push_ready),  8'(m_push_ready()));
        chk("mdl_enable_in",   8'(enable_in),   8'(m_rdy));
        chk("mdl_valid_in",    8'(valid_in),    8'(v));
        chk("mdl_wr_rd_op",    8'(wr_rd_op),    v ? 8'(m_q[0].wr) : 8'h00);
        chk("mdl_addr_in",     addr_in,         v ? m_q[0].addr : 8'h00);
        chk("mdl_wr_data_in",  wr_data_in,      v ? m_q[0].data : 8'h00);
        chk("mdl_op_id_in",    op_id_in,        v ? 8'(m_nid) : 8'h00);
        chk("mdl_cpl_valid",   8'(cpl_valid),   8'(m_cpl_v));
        chk("mdl_cpl_op_id",   cpl_op_id,       8'(m_cpl_id));
        chk("mdl_cpl_wr_rd",   8'(cpl_wr_rd),   8'(m_cpl_wr));
        chk("mdl_cpl_rd_data", cpl_rd_data,     m_cpl_rd);
        chk("mdl_cpl_err",     8'(cpl_err),     8'(m_err));
        chk("mdl_outstanding", outstanding,     8'(m_issued.size()));
    endtask

    task automatic tick();
        model_next();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 0; push_valid = 0; done_op_id = 0; ready_out = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    // Push one request, see it issue with the expected ID, optionally complete it
    task automatic pair(input int id, input bit hold);
        push_valid = 1; push_wr_rd = 1'($urandom); push_addr = 8'($urandom);
        push_data = 8'($urandom); ready_out = 1;
        tick();
        push_valid = 0;
        chk("pair_valid", 8'(valid_in), 8'h01);
        chk("pair_id", op_id_in, 8'(id));
        chk("pair_id_nonzero", 8'(op_id_in == 8'h00), 8'h00);
        tick();
        if (!hold) begin
            done_op_id = 8'(id); rd_data_out = 8'($urandom);
            tick();
            done_op_id = 0;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] pv, wr, a, d, rdy, dn, rd;
        logic [7:0] ev, eid, ewr, ea, ed, ecv, ecid, ecwr, ecrd, eout;
    } vec_t;

    vec_t tbl[8];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int id;
        int hs;
        int budget;

        //        pv  wr  a     d     rdy dn  rd     ev  eid ewr ea    ed    ecv ecid ecwr ecrd  eout
        tbl[0] = '{1, 1, 8'h12, 8'hA5, 1, 0, 8'h00, 1, 1, 1, 8'h12, 8'hA5, 0, 0, 0, 8'h00, 0};
        tbl[1] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1};
        tbl[2] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h77, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h00, 0};
        tbl[3] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0};
        tbl[4] = '{1, 0, 8'h34, 8'h00, 0, 0, 8'h00, 1, 2, 0, 8'h34, 8'h00, 0, 0, 0, 8'h00, 0};
        tbl[5] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 2, 0, 8'h34, 8'h00, 0, 0, 0, 8'h00, 0};
        tbl[6] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1};
        tbl[7] = '{0, 0, 8'h00, 8'h00, 1, 2, 8'hC3, 0, 0, 0, 8'h00, 8'h00, 1, 2, 0, 8'hC3, 0};

        rst_n = 0; push_valid = 0; push_wr_rd = 0; push_addr = 0; push_data = 0;
        ready_out = 0; done_op_id = 0; rd_data_out = 0;
        tick(); tick();
        chk("rst_push_ready", 8'(push_ready), 8'h00);
        chk("rst_enable_in", 8'(enable_in), 8'h00);
        chk("rst_valid_in", 8'(valid_in), 8'h00);
        chk("rst_outstanding", outstanding, 8'h00);
        rst_n = 1;
        tick();
        chk("post_rst_push_ready", 8'(push_ready), 8'h01);
        chk("post_rst_enable_in", 8'(enable_in), 8'h01);

        // Table: single write round trip, then a held read round trip
        for (int i = 0; i < 8; i++) begin
            push_valid = tbl[i].pv[0]; push_wr_rd = tbl[i].wr[0];
            push_addr = tbl[i].a; push_data = tbl[i].d; ready_out = tbl[i].rdy[0];
            done_op_id = tbl[i].dn; rd_data_out = tbl[i].rd;
            tick();
            chk($sformatf("tbl%0d_valid", i), 8'(valid_in), tbl[i].ev);
            chk($sformatf("tbl%0d_op_id", i), op_id_in, tbl[i].eid);
            chk($sformatf("tbl%0d_wr_rd", i), 8'(wr_rd_op), tbl[i].ewr);
            chk($sformatf("tbl%0d_addr", i), addr_in, tbl[i].ea);
            chk($sformatf("tbl%0d_data", i), wr_data_in, tbl[i].ed);
            chk($sformatf("tbl%0d_cpl_valid", i), 8'(cpl_valid), tbl[i].ecv);
            chk($sformatf("tbl%0d_cpl_id", i), cpl_op_id, tbl[i].ecid);
            chk($sformatf("tbl%0d_cpl_wr", i), 8'(cpl_wr_rd), tbl[i].ecwr);
            chk($sformatf("tbl%0d_cpl_rd", i), cpl_rd_data, tbl[i].ecrd);
            chk($sformatf("tbl%0d_outstanding", i), outstanding, tbl[i].eout);
        end
        push_valid = 0; done_op_id = 0;

        // Fill the FIFO with the decoder stalled; the 9th push must be dropped
        ready_out = 0;
        for (int i = 0; i < 8; i++) begin
            push_valid = 1; push_wr_rd = 1; push_addr = 8'(8'h80 + i); push_data = 8'(i);
            tick();
        end
        chk("fill_push_ready", 8'(push_ready), 8'h00);
        push_addr = 8'h99;
        tick();
        push_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 8'(valid_in), 8'h01);
            chk("hold_addr", addr_in, 8'h80);
            chk("hold_op_id", op_id_in, 8'h03);
        end
        ready_out = 1;
        hs = 0;
        budget = 100;
        while (budget > 0 && (m_q.size() > 0 || m_issued.size() > 0)) begin
            if (valid_in && ready_out) hs++;
            done_op_id = (m_issued.size() > 0) ? 8'(m_issued[0]) : 8'h00;
            tick();
            budget--;
        end
        done_op_id = 0;
        chk("drain_done", 8'(m_q.size() + m_issued.size()), 8'h00);
        chk("drain_count", 8'(hs), 8'h08);

        // Outstanding limit of 2 holds back the third read
        do_reset();
        ready_out = 1;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1; push_wr_rd = 0; push_addr = 8'(8'h50 + i); push_data = 0;
            tick();
        end
        push_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("limit_valid", 8'(valid_in), 8'h00);
            chk("limit_outstanding", outstanding, 8'h02);
        end
        done_op_id = 1; rd_data_out = 8'h3C;
        tick();
        done_op_id = 0;
        chk("limit_cpl_valid", 8'(cpl_valid), 8'h01);
        chk("limit_cpl_rd", cpl_rd_data, 8'h3C);
        chk("limit_next_valid", 8'(valid_in), 8'h01);
        chk("limit_next_id", op_id_in, 8'h03);
        tick();
        done_op_id = 2; tick();
        done_op_id = 3; tick();
        done_op_id = 0; tick();
        chk("limit_empty", outstanding, 8'h00);

        // 255 issue/complete pairs: IDs run 4..255 then wrap to 1
        id = 4;
        for (int k = 0; k < 255; k++) begin
            pair(id, 1'b0);
            id = (id == 255) ? 1 : id + 1;
        end

        // ID 5 left in flight while the allocator comes back round to it
        pair(id, 1'b0);
        id = (id == 255) ? 1 : id + 1;
        chk("busy_id_is5", 8'(id), 8'h05);
        pair(id, 1'b1);
        id = 6;
        for (int k = 0; k < 254; k++) begin
            pair(id, 1'b0);
            id = (id == 255) ? 1 : id + 1;
        end
        push_valid = 1; push_wr_rd = 0; push_addr = 8'h55; push_data = 0; ready_out = 1;
        tick();
        push_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("busy_blocked", 8'(valid_in), 8'h00);
            tick();
        end
        done_op_id = 5; rd_data_out = 8'h11;
        tick();
        done_op_id = 0;
        chk("busy_cpl", cpl_op_id, 8'h05);
        chk("busy_reissue_valid", 8'(valid_in), 8'h01);
        chk("busy_reissue_id", op_id_in, 8'h05);
        tick();
        done_op_id = 5; tick();
        done_op_id = 0; tick();

        // Unknown ID completion sets a sticky error
        done_op_id = 8'h40;
        tick();
        done_op_id = 0;
        chk("unk_cpl_valid", 8'(cpl_valid), 8'h00);
        chk("unk_err", 8'(cpl_err), 8'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("unk_err_hold", 8'(cpl_err), 8'h01);
        end

        // Reset in the middle of traffic
        ready_out = 0;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1; push_wr_rd = 0; push_addr = 8'(8'h20 + i);
            tick();
        end
        push_valid = 0; ready_out = 1;
        tick(); tick();
        rst_n = 0; push_valid = 1;
        tick();
        chk("mid_rst_push_ready", 8'(push_ready), 8'h00);
        chk("mid_rst_enable", 8'(enable_in), 8'h00);
        chk("mid_rst_valid", 8'(valid_in), 8'h00);
        chk("mid_rst_op_id", op_id_in, 8'h00);
        chk("mid_rst_cpl_valid", 8'(cpl_valid), 8'h00);
        chk("mid_rst_cpl_err", 8'(cpl_err), 8'h00);
        chk("mid_rst_outstanding", outstanding, 8'h00);
        rst_n = 1; push_valid = 0;
        tick();
        chk("mid_rel_push_ready", 8'(push_ready), 8'h01);
        chk("mid_rel_valid", 8'(valid_in), 8'h00);
        done_op_id = 1;
        tick();
        done_op_id = 0;
        chk("stale_cpl_valid", 8'(cpl_valid), 8'h00);
        chk("stale_cpl_err", 8'(cpl_err), 8'h01);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst_n       = ($urandom_range(0, 399) != 0);
            push_valid  = 1'($urandom_range(0, 1));
            push_wr_rd  = 1'($urandom);
            push_addr   = 8'($urandom);
            push_data   = 8'($urandom);
            ready_out   = ($urandom_range(0, 3) != 0);
            rd_data_out = 8'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 60 && m_issued.size() > 0)
                done_op_id = 8'(m_issued[$urandom_range(0, m_issued.size() - 1)]);
            else if (r < 64)
                done_op_id = 8'($urandom_range(1, 255));
            else
                done_op_id = 8'h00;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_dec_req_issuer.md
Name: addr_dec_req_issuer

Overview:
- Upstream stage of the 4-switch unit address decoder.
- Buffers host read/write requests in a FIFO and assigns each one a unique non-zero op ID.
- Drives the decoder request bus (enable_in/valid_in/wr_rd_op/addr_in/op_id_in/wr_data_in) under a valid/ready handshake.
- Tracks outstanding op IDs and converts decoder completions (done_op_id, rd_data_out) into one-cycle host completion pulses.

Parameters:
- DEPTH, 8, request FIFO entries; power of 2, range 2..64.
- MAX_OUTSTANDING, 16, maximum issued-but-not-completed ops; range 1..255.

Ports:
- clock  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- push_valid  in  1  host request valid.
- push_ready  out  1  FIFO not full; a push transfers when push_valid && push_ready.
- push_wr_rd  in  1  1 = write, 0 = read.
- push_addr  in  8  target address.
- push_data  in  8  write data; ignored for reads.
- enable_in  out  1  decoder enable.
- valid_in  out  1  request valid to decoder.
- wr_rd_op  out  1  request type.
- addr_in  out  8  request address.
- op_id_in  out  8  request op ID.
- wr_data_in  out  8  request write data.
- ready_out  in  1  decoder accepts; an issue transfers when valid_in && ready_out.
- done_op_id  in  8  completed op ID; 0 = no completion this cycle.
- rd_data_out  in  8  read data, valid with a non-zero done_op_id.
- cpl_valid  out  1  completion pulse.
- cpl_op_id  out  8  completed ID.
- cpl_wr_rd  out  1  type of the completed op.
- cpl_rd_data  out  8  read data; 0 for writes.
- cpl_err  out  1  sticky: unknown ID was completed.
- outstanding  out  8  count of outstanding ops.

Behaviour:
- Reset (rst_n low at an edge):
  - FIFO emptied; bitmap cleared; next_id = 1; outstanding = 0.
  - All outputs 0, except push_ready, which is 0 during reset and 1 from the first cycle after.
  - enable_in = 0 during reset and 1 thereafter.
  - Reset mid-operation discards all queued and outstanding ops with no completions; completions arriving afterwards flag cpl_err.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits wide; full/empty are derived from the pointers.
  - push_ready = !full, registered-state based. A push while full is dropped.
  - A simultaneous push and issue while full is not accepted; push_ready is already 0.
- Issue:
  - valid_in = !empty && !stall, where stall = (outstanding == MAX_OUTSTANDING) || bitmap[next_id].
  - wr_rd_op/addr_in/wr_data_in come from the FIFO head; op_id_in = next_id.
  - All request outputs hold stable while valid_in && !ready_out.
  - Stall only becomes true via an issue, so valid_in never drops without a handshake.
  - Minimum latency: a push at edge N gives valid_in high after edge N.
  - On handshake: pop the head, set bitmap[next_id], store wr_rd[next_id], outstanding++, advance next_id.
  - next_id wraps from 255 to 1; ID 0 is never issued.
- Completion:
  - A non-zero done_op_id with bitmap set:
    - clear the bit and decrement outstanding;
    - next cycle: cpl_valid = 1, cpl_op_id = done_op_id, cpl_wr_rd = stored type, cpl_rd_data = rd_data_out if read else 0.
  - A non-zero done_op_id with bitmap clear:
    - no cpl_valid; cpl_err is set and held until reset;
    - this includes an ID equal to the one being issued in the same cycle.
  - Issue and completion in the same cycle: outstanding is unchanged; both bitmap updates apply.
- State machine: none beyond the FIFO and scoreboard. Issue is a combinational function of registered state.

Optional Feature:
- Macro: ADDR_DEC_REQ_TIMEOUT_EN.
- When defined:
  - Adds a 16-bit age counter, cleared on any completion.
  - It increments each cycle while outstanding > 0.
  - When it reaches 0xFFFF, output port timeout_err (1 bit, sticky until reset) is set.
- When undefined: no counter and no timeout_err port.

Decomposition:
- Shared package addr_dec_req_pkg holds:
  - typedef req_t (wr_rd, addr[7:0], data[7:0]);
  - localparam OP_ID_NONE = 8'h00;
  - localparam OP_ID_FIRST = 8'h01.
- One sub-module, addr_dec_req_fifo: a parameterised synchronous FIFO of req_t with full/empty flags.
- The scoreboard and ID logic stay in the top module.

Test Plan:
- Reset, then push write addr 0x12 data 0xA5 with ready_out = 1 -> valid_in next cycle, op_id_in = 1, wr_rd_op = 1; done_op_id = 1 later -> cpl_valid, cpl_rd_data = 0.
- Fill 8 pushes with ready_out = 0 -> push_ready = 0 after the 8th; a 9th push is dropped; request outputs are held stable for 10 cycles.
- MAX_OUTSTANDING = 2, three reads, no completions -> only IDs 1 and 2 issue; done_op_id = 1 with rd_data_out = 0x3C -> ID 3 issues; cpl_rd_data = 0x3C.
- 255 issue/complete pairs -> next_id wraps 255 -> 1; op_id_in is never 0.
- ID 5 left outstanding while next_id wraps to 5 -> valid_in low until done_op_id = 5, then ID 5 is reissued.
- done_op_id = 0x40 with nothing outstanding -> no cpl_valid; cpl_err = 1 and holds; reset mid-traffic -> all outputs 0, outstanding = 0.
